// File: rtl/cond_if.sv
// cond_if: execute-stage condition unit signal bundle (decoder/ALU side drives master)
interface cond_if #(parameter int CNT_W = 16);
    logic             InstrValid;
    logic             Stall;
    logic [3:0]       Cond;
    logic [3:0]       ALUFlags;
    logic [1:0]       FlagW;
    logic             PCS;
    logic             RegW;
    logic             MemW;
    logic             NoWrite;
    logic             CntClr;
    logic             SaveFlags;
    logic             RestoreFlags;
    logic             CondEx;
    logic             PCSrc;
    logic             RegWrite;
    logic             MemWrite;
    logic [3:0]       Flags;
    logic [3:0]       SavedFlags;
    logic [CNT_W-1:0] CondFailCnt;

    modport master (
        output InstrValid, Stall, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
               CntClr, SaveFlags, RestoreFlags,
        input  CondEx, PCSrc, RegWrite, MemWrite, Flags, SavedFlags, CondFailCnt
    );

    modport slave (
        input  InstrValid, Stall, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
               CntClr, SaveFlags, RestoreFlags,
        output CondEx, PCSrc, RegWrite, MemWrite, Flags, SavedFlags, CondFailCnt
    );
endinterface

// File: rtl/cond_unit.sv
// cond_unit: NZCV flag register, condition check, write gating, fail counter; COND_FLAG_SAVE_EN adds flag save/restore
module cond_unit #(
    parameter int CNT_W = 16
) (
    input logic   clk,
    input logic   reset,
    cond_if.slave bus
);
    logic             cond_ex;
    logic             upd;
    logic             fail;
    logic [3:0]       flags;
    logic [3:0]       nxt_flags;
    logic [CNT_W-1:0] cnt;
    logic             n, z, c, v;

    assign {n, z, c, v} = flags;

    // condition check against the registered flags only
    always_comb begin
        cond_ex = 1'b0;
        case (bus.Cond)
            4'h0: cond_ex = z;
            4'h1: cond_ex = ~z;
            4'h2: cond_ex = c;
            4'h3: cond_ex = ~c;
            4'h4: cond_ex = n;
            4'h5: cond_ex = ~n;
            4'h6: cond_ex = v;
            4'h7: cond_ex = ~v;
            4'h8: cond_ex = c & ~z;
            4'h9: cond_ex = ~c | z;
            4'hA: cond_ex = (n == v);
            4'hB: cond_ex = (n != v);
            4'hC: cond_ex = ~z & (n == v);
            4'hD: cond_ex = z | (n != v);
            4'hE: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    assign upd  = bus.InstrValid & ~bus.Stall & cond_ex;
    assign fail = bus.InstrValid & ~bus.Stall & ~cond_ex;

    assign bus.CondEx      = cond_ex;
    assign bus.PCSrc       = bus.PCS & cond_ex & bus.InstrValid;
    assign bus.RegWrite    = bus.RegW & ~bus.NoWrite & cond_ex & bus.InstrValid;
    assign bus.MemWrite    = bus.MemW & cond_ex & bus.InstrValid;
    assign bus.Flags       = flags;
    assign bus.CondFailCnt = cnt;

`ifdef COND_FLAG_SAVE_EN
    logic [3:0] saved;

    // shadow copy captures the pre-update flags
    always_ff @(posedge clk or posedge reset)
        if (reset) saved <= 4'b0;
        else if (~bus.Stall & bus.SaveFlags) saved <= flags;

    assign bus.SavedFlags = saved;
`else
    logic unused_save;

    assign unused_save    = bus.SaveFlags ^ bus.RestoreFlags;
    assign bus.SavedFlags = 4'b0;
`endif

    // per-half ALU flag write; restore wins over any ALU write
    always_comb begin
        nxt_flags[3:2] = (upd & bus.FlagW[1]) ? bus.ALUFlags[3:2] : flags[3:2];
        nxt_flags[1:0] = (upd & bus.FlagW[0]) ? bus.ALUFlags[1:0] : flags[1:0];
`ifdef COND_FLAG_SAVE_EN
        if (~bus.Stall & bus.RestoreFlags) nxt_flags = saved;
`endif
    end

    // architectural flag register
    always_ff @(posedge clk or posedge reset)
        if (reset) flags <= 4'b0;
        else flags <= nxt_flags;

    // saturating fail counter; clear wins and ignores stall
    always_ff @(posedge clk or posedge reset)
        if (reset) cnt <= '0;
        else if (bus.CntClr) cnt <= '0;
        else if (fail && cnt != {CNT_W{1'b1}}) cnt <= cnt + 1'b1;
endmodule
